// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: RV32I word/register/mask widths,
// load/store funct3 encodings and the LSU state encoding.
package load_store_unit_pkg;

  typedef logic [31:0] rv32i_word;
  typedef logic [4:0]  rv32i_reg;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-request, data-memory and writeback-response signals of the LSU.
// slave is the LSU's view; master is the surrounding pipeline/memory.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic           req_valid;
  logic           req_ready;
  logic           req_is_store;
  logic [2:0]     req_funct3;
  rv32i_word      req_addr;
  rv32i_word      req_wdata;
  rv32i_reg       req_rd;

  logic           mem_read;
  logic           mem_write;
  rv32i_word      mem_address;
  rv32i_word      mem_wdata;
  rv32i_mem_wmask mem_byte_enable;
  logic           mem_resp;
  rv32i_word      mem_rdata;

  logic           rsp_valid;
  rv32i_reg       rsp_rd;
  rv32i_word      rsp_data;
  logic           rsp_fault;

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata,
    input  rsp_valid, rsp_rd, rsp_data, rsp_fault
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata,
    output rsp_valid, rsp_rd, rsp_data, rsp_fault
  );

endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane logic: store mask and lane replication, load alignment with
// sign/zero extension, and misalignment / illegal-funct3 detection.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]     funct3,
  input  logic           is_store,
  input  logic [1:0]     off,
  input  rv32i_word      wdata,
  input  rv32i_word      rdata,
  output rv32i_mem_wmask wmask,
  output rv32i_word      lane_wdata,
  output rv32i_word      load_data,
  output logic           misaligned,
  output logic           illegal
);

  rv32i_word shifted;

  always_comb begin
    wmask      = '0;
    lane_wdata = '0;
    load_data  = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    shifted    = rdata >> {off, 3'b000};
    if (is_store) begin
      case (funct3)
        sb: begin
          wmask      = 4'b0001 << off;
          lane_wdata = {4{wdata[7:0]}};
        end
        sh: begin
          wmask      = 4'b0011 << off;
          lane_wdata = {2{wdata[15:0]}};
          misaligned = off[0];
        end
        sw: begin
          wmask      = 4'b1111;
          lane_wdata = wdata;
          misaligned = |off;
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        lb:  load_data = {{24{shifted[7]}}, shifted[7:0]};
        lbu: load_data = {24'h0, shifted[7:0]};
        lh: begin
          load_data  = {{16{shifted[15]}}, shifted[15:0]};
          misaligned = off[0];
        end
        lhu: begin
          load_data  = {16'h0, shifted[15:0]};
          misaligned = off[0];
        end
        lw: begin
          load_data  = rdata;
          misaligned = |off;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: accepts one load/store, holds the memory request until
// mem_resp, then returns one response pulse to writeback.
//
//   state | meaning
//   IDLE  | ready for a request; a bad op jumps straight to DONE with fault
//   MEM   | strobe held from latched request until mem_resp
//   DONE  | one-cycle response pulse
module load_store_unit
  import load_store_unit_pkg::*;
(
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  lsu_state_t     state, state_next;
  logic           is_store_q;
  logic [2:0]     funct3_q;
  rv32i_word      addr_q, wdata_q;
  rv32i_reg       rd_q;
  rv32i_word      rsp_data_q;
  rv32i_reg       rsp_rd_q;
  logic           rsp_fault_q;

  logic           accept, op_bad;
  logic [2:0]     a_funct3;
  logic           a_is_store;
  logic [1:0]     a_off;
  rv32i_word      a_wdata;
  rv32i_mem_wmask a_wmask;
  rv32i_word      a_lane_wdata, a_load_data;
  logic           a_misaligned, a_illegal;

  assign accept = (state == IDLE) && bus.req_valid;
  assign op_bad = a_misaligned | a_illegal;

  // Live request decides legality at accept; latched copy drives MEM.
  always_comb begin
    if (state == IDLE) begin
      a_funct3   = bus.req_funct3;
      a_is_store = bus.req_is_store;
      a_off      = bus.req_addr[1:0];
      a_wdata    = bus.req_wdata;
    end else begin
      a_funct3   = funct3_q;
      a_is_store = is_store_q;
      a_off      = addr_q[1:0];
      a_wdata    = wdata_q;
    end
  end

  load_store_unit_align u_align (
    .funct3     (a_funct3),
    .is_store   (a_is_store),
    .off        (a_off),
    .wdata      (a_wdata),
    .rdata      (bus.mem_rdata),
    .wmask      (a_wmask),
    .lane_wdata (a_lane_wdata),
    .load_data  (a_load_data),
    .misaligned (a_misaligned),
    .illegal    (a_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req_valid) state_next = op_bad ? DONE : MEM;
      MEM:     if (bus.mem_resp)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      is_store_q  <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_fault_q <= 1'b0;
    end else if (accept) begin
      is_store_q  <= bus.req_is_store;
      funct3_q    <= bus.req_funct3;
      addr_q      <= bus.req_addr;
      wdata_q     <= bus.req_wdata;
      rd_q        <= bus.req_rd;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_fault_q <= op_bad;
    end else if ((state == MEM) && bus.mem_resp && !is_store_q) begin
      rsp_data_q  <= a_load_data;
      rsp_rd_q    <= rd_q;
    end
  end

  always_comb begin
    bus.req_ready       = (state == IDLE);
    bus.mem_read        = (state == MEM) && !is_store_q;
    bus.mem_write       = (state == MEM) && is_store_q;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = '0;
    bus.rsp_valid       = (state == DONE);
    bus.rsp_rd          = '0;
    bus.rsp_data        = '0;
    bus.rsp_fault       = 1'b0;
    if (state == MEM) begin
      bus.mem_address     = {addr_q[31:2], 2'b00};
      bus.mem_wdata       = is_store_q ? a_lane_wdata : '0;
      bus.mem_byte_enable = is_store_q ? a_wmask : 4'b1111;
    end
    if (state == DONE) begin
      bus.rsp_rd    = rsp_rd_q;
      bus.rsp_data  = rsp_data_q;
      bus.rsp_fault = rsp_fault_q;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed ops push expected memory
// requests and responses; negedge monitors pop and compare.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        fault;
  } rsp_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mreq_t;

  rsp_t  exp_q[$];
  mreq_t mexp_q[$];
  int    rsp_cyc[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  logic  prev_strobe = 1'b0;
  mreq_t held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor
  always @(negedge clk) begin
    rsp_t e;
    if (bus.rsp_valid === 1'b1) begin
      rsp_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d with no response expected", cyc);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rd", {27'h0, bus.rsp_rd}, {27'h0, e.rd});
        check("rsp_data", bus.rsp_data, e.data);
        check("rsp_fault", {31'h0, bus.rsp_fault}, {31'h0, e.fault});
      end
    end
  end

  // Memory-request monitor
  always @(negedge clk) begin
    mreq_t m;
    logic  strobe;
    strobe = bus.mem_read | bus.mem_write;
    if (strobe && !prev_strobe) begin
      if (mexp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_mem: strobe at cycle %0d addr 0x%08h", cyc, bus.mem_address);
      end else begin
        m = mexp_q.pop_front();
        check("mem_write_flag", {31'h0, bus.mem_write}, {31'h0, m.write});
        check("mem_address", bus.mem_address, m.addr);
        check("mem_byte_enable", {28'h0, bus.mem_byte_enable}, {28'h0, m.be});
        if (m.write) check("mem_wdata", bus.mem_wdata, m.wdata);
      end
      held.write <= bus.mem_write;
      held.addr  <= bus.mem_address;
      held.wdata <= bus.mem_wdata;
      held.be    <= bus.mem_byte_enable;
    end else if (strobe) begin
      check("mem_hold_write", {31'h0, bus.mem_write}, {31'h0, held.write});
      check("mem_hold_addr", bus.mem_address, held.addr);
      check("mem_hold_wdata", bus.mem_wdata, held.wdata);
      check("mem_hold_be", {28'h0, bus.mem_byte_enable}, {28'h0, held.be});
    end else begin
      check("idle_mem_address", bus.mem_address, 32'h0);
      check("idle_mem_be", {28'h0, bus.mem_byte_enable}, 32'h0);
      check("idle_mem_wdata", bus.mem_wdata, 32'h0);
    end
    prev_strobe <= strobe;
  end

  task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_rd       = rd;
  endtask

  task automatic clear_req();
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'b000;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_rd       = 5'h0;
  endtask

  task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input int k, input logic [31:0] rdata, input logic exp_fault,
                        input logic [4:0] exp_rd, input logic [31:0] exp_data,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata);
    int    strobes = 0;
    rsp_t  r;
    mreq_t m;
    check({tag, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
    r.rd = exp_rd; r.data = exp_data; r.fault = exp_fault;
    exp_q.push_back(r);
    if (!exp_fault) begin
      m.write = st; m.addr = exp_addr; m.wdata = exp_wdata; m.be = exp_be;
      mexp_q.push_back(m);
    end
    drive_req(st, f3, a, wd, rd);
    @(posedge clk); #1;
    clear_req();
    if (exp_fault) begin
      check({tag, "_fault_latency"}, {31'h0, bus.rsp_valid}, 32'h1);
      check({tag, "_no_strobe"}, {31'h0, bus.mem_read | bus.mem_write}, 32'h0);
    end else begin
      for (int i = 1; i <= k; i++) begin
        if (bus.mem_read | bus.mem_write) strobes++;
        if (i == k) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = rdata;
        end
        @(posedge clk); #1;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 32'h0;
      end
      check({tag, "_strobe_cycles"}, strobes, k);
      check({tag, "_rsp_latency"}, {31'h0, bus.rsp_valid}, 32'h1);
    end
    @(posedge clk); #1;
    check({tag, "_rsp_single"}, {31'h0, bus.rsp_valid}, 32'h0);
    check({tag, "_rsp_drained"}, exp_q.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] rdy;
    int         base;
    rsp_t       r;
    mreq_t      m;

    clear_req();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 32'h0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst_mem_read", {31'h0, bus.mem_read}, 32'h0);
    check("rst_mem_write", {31'h0, bus.mem_write}, 32'h0);
    check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_mem_address", bus.mem_address, 32'h0);
    check("rst_mem_be", {28'h0, bus.mem_byte_enable}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    //      tag       st  f3      addr          wdata         rd  k  rdata         flt rd  data          addr          be       wdata
    run_op("sw",      1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 7, 3, 32'h0,        0, 0, 32'h0,        32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    run_op("sb",      1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 3, 1, 32'h0,        0, 0, 32'h0,        32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
    run_op("sh",      1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 0, 2, 32'h0,        0, 0, 32'h0,        32'h0000_0100, 4'b1100, 32'hBEEF_BEEF);
    run_op("lb",      0, 3'b000, 32'h0000_0202, 32'h0,         5, 2, 32'h12F0_3456, 0, 5, 32'hFFFF_FFF0, 32'h0000_0200, 4'b1111, 32'h0);
    run_op("lbu",     0, 3'b100, 32'h0000_0202, 32'h0,         5, 1, 32'h12F0_3456, 0, 5, 32'h0000_00F0, 32'h0000_0200, 4'b1111, 32'h0);
    run_op("lh",      0, 3'b001, 32'h0000_0302, 32'h0,         8, 1, 32'h8001_1234, 0, 8, 32'hFFFF_8001, 32'h0000_0300, 4'b1111, 32'h0);
    run_op("lhu",     0, 3'b101, 32'h0000_0302, 32'h0,         8, 1, 32'h8001_1234, 0, 8, 32'h0000_8001, 32'h0000_0300, 4'b1111, 32'h0);
    run_op("lw",      0, 3'b010, 32'h0000_0400, 32'h0,        31, 4, 32'hCAFE_F00D, 0,31, 32'hCAFE_F00D, 32'h0000_0400, 4'b1111, 32'h0);
    run_op("lb_off3", 0, 3'b000, 32'h0000_0503, 32'h0,         4, 1, 32'h8000_0000, 0, 4, 32'hFFFF_FF80, 32'h0000_0500, 4'b1111, 32'h0);
    run_op("lh_mis",  0, 3'b001, 32'h0000_0301, 32'h0,         9, 1, 32'h0,        1, 0, 32'h0,        32'h0,         4'b0000, 32'h0);
    run_op("ld_ill3", 0, 3'b011, 32'h0000_0000, 32'h0,        10, 1, 32'h0,        1, 0, 32'h0,        32'h0,         4'b0000, 32'h0);
    run_op("ld_ill6", 0, 3'b110, 32'h0000_0008, 32'h0,        10, 1, 32'h0,        1, 0, 32'h0,        32'h0,         4'b0000, 32'h0);
    run_op("st_ill3", 1, 3'b011, 32'h0000_0000, 32'h1,        10, 1, 32'h0,        1, 0, 32'h0,        32'h0,         4'b0000, 32'h0);
    run_op("sw_mis",  1, 3'b010, 32'h0000_0102, 32'h1,         2, 1, 32'h0,        1, 0, 32'h0,        32'h0,         4'b0000, 32'h0);
    run_op("lw_mis",  0, 3'b010, 32'h0000_0402, 32'h0,         2, 1, 32'h0,        1, 0, 32'h0,        32'h0,         4'b0000, 32'h0);
    run_op("sh_mis",  1, 3'b001, 32'h0000_0103, 32'h1,         2, 1, 32'h0,        1, 0, 32'h0,        32'h0,         4'b0000, 32'h0);

    // Reset while waiting in MEM drops the op; a late mem_resp is ignored.
    m.write = 1'b0; m.addr = 32'h0000_0600; m.wdata = 32'h0; m.be = 4'b1111;
    mexp_q.push_back(m);
    check("rstmem_ready", {31'h0, bus.req_ready}, 32'h1);
    drive_req(1'b0, 3'b010, 32'h0000_0600, 32'h0, 5'd11);
    @(posedge clk); #1;
    clear_req();
    check("rstmem_read_high", {31'h0, bus.mem_read}, 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rstmem_read_low", {31'h0, bus.mem_read}, 32'h0);
    check("rstmem_ready_after", {31'h0, bus.req_ready}, 32'h1);
    check("rstmem_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 32'h0;
    check("late_resp_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
    check("late_resp_ready", {31'h0, bus.req_ready}, 32'h1);
    check("late_resp_no_strobe", {31'h0, bus.mem_read | bus.mem_write}, 32'h0);
    @(posedge clk); #1;
    check("late_resp_idle_rsp", {31'h0, bus.rsp_valid}, 32'h0);

    // Back-to-back loads with mem_resp in the first MEM cycle.
    m.write = 1'b0; m.wdata = 32'h0; m.be = 4'b1111;
    m.addr = 32'h0000_0700; mexp_q.push_back(m);
    m.addr = 32'h0000_0704; mexp_q.push_back(m);
    r.fault = 1'b0;
    r.rd = 5'd1; r.data = 32'h1111_1111; exp_q.push_back(r);
    r.rd = 5'd2; r.data = 32'h2222_2222; exp_q.push_back(r);
    base = rsp_cyc.size();
    rdy[6] = bus.req_ready;
    drive_req(1'b0, 3'b010, 32'h0000_0700, 32'h0, 5'd1);
    @(posedge clk); #1;
    rdy[5] = bus.req_ready;
    clear_req();
    bus.mem_resp = 1'b1; bus.mem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    rdy[4] = bus.req_ready;
    bus.mem_resp = 1'b0; bus.mem_rdata = 32'h0;
    drive_req(1'b0, 3'b010, 32'h0000_0704, 32'h0, 5'd2);
    @(posedge clk); #1;
    rdy[3] = bus.req_ready;
    @(posedge clk); #1;
    rdy[2] = bus.req_ready;
    clear_req();
    bus.mem_resp = 1'b1; bus.mem_rdata = 32'h2222_2222;
    @(posedge clk); #1;
    rdy[1] = bus.req_ready;
    bus.mem_resp = 1'b0; bus.mem_rdata = 32'h0;
    @(posedge clk); #1;
    rdy[0] = bus.req_ready;
    check("b2b_ready_pattern", {25'h0, rdy}, {25'h0, 7'b1001001});
    check("b2b_rsp_count", rsp_cyc.size() - base, 32'd2);
    if (rsp_cyc.size() - base == 2)
      check("b2b_rsp_spacing", rsp_cyc[base + 1] - rsp_cyc[base], 32'd3);

    repeat (3) @(posedge clk);
    #1;
    check("final_rsp_queue", exp_q.size(), 32'h0);
    check("final_mem_queue", mexp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
